// File: rtl/mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump
//  Description : Memory readout engine. On a start pulse it sweeps an
//                inclusive address range (wrapping through the top of the
//                address space when first_addr > last_addr) through a
//                synchronous read port and streams every word, tagged with
//                its address, over a valid/ready interface.
//                Optional feature macro: MEM_DUMP_CHECKSUM_EN adds a running
//                modulo-2^INSTR_SIZE sum of all handshaked words on port
//                'checksum'.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dump #(
    parameter int INSTR_SIZE = 12,
    parameter int ADDR_SIZE  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  first_addr,
    input  logic [ADDR_SIZE-1:0]  last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_SIZE-1:0]  mem_rd_addr,
    input  logic [INSTR_SIZE-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_SIZE-1:0]  out_addr,
    output logic [INSTR_SIZE-1:0] out_data
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [INSTR_SIZE-1:0] checksum
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE = 3'd0;   // waiting for start
    localparam logic [2:0] c_REQ  = 3'd1;   // read strobe to memory
    localparam logic [2:0] c_LOAD = 3'd2;   // capture read data
    localparam logic [2:0] c_SEND = 3'd3;   // present word to consumer
    localparam logic [2:0] c_FIN  = 3'd4;   // one-cycle done pulse

    localparam logic [ADDR_SIZE-1:0] c_ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registers and combinational controls
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_SIZE-1:0]  r_cur;        // address of the word being fetched
    logic [ADDR_SIZE-1:0]  r_end;        // inclusive end of the sweep
    logic [ADDR_SIZE-1:0]  r_out_addr;
    logic [INSTR_SIZE-1:0] r_out_data;
    logic                  w_start_acc;  // start accepted this cycle
    logic                  w_handshake;  // word leaves this cycle
    logic                  w_last_word;  // current word is the final one

    // The end test is an equality, so a wrapped range (first > last) simply
    // counts through the top of the address space until it meets r_end.
    assign w_last_word = (r_cur == r_end);

    // The read address follows the sweep pointer; r_cur only moves on a
    // handshake in SEND, so it is stable whenever the strobe is high and
    // holds its last value otherwise.
    assign mem_rd_addr = r_cur;
    assign out_addr    = r_out_addr;
    assign out_data    = r_out_data;

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore/handshake outputs; busy covers REQ..SEND only so
    // that it drops in the same cycle done is raised.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        out_valid   = 1'b0;
        w_start_acc = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                w_state_nxt = c_LOAD;
            end
            c_LOAD: begin
                busy        = 1'b1;
                w_state_nxt = c_SEND;
            end
            c_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = w_last_word ? c_FIN : c_REQ;
                end
            end
            c_FIN: begin
                done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Sweep pointer and range capture. Start outside IDLE never reaches
    // here because w_start_acc is only raised in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur <= '0;
            r_end <= '0;
        end else if (w_start_acc) begin
            r_cur <= first_addr;
            r_end <= last_addr;
        end else if (w_handshake && !w_last_word) begin
            r_cur <= r_cur + c_ADDR_ONE;
        end
    end

    // Output word register: loaded only in LOAD, so it stays frozen for the
    // whole SEND phase regardless of how long the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_addr <= '0;
            r_out_data <= '0;
        end else if (r_state == c_LOAD) begin
            r_out_addr <= r_cur;
            r_out_data <= mem_rd_data;
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [INSTR_SIZE-1:0] r_checksum;

    // Running sum of delivered words; cleared when a new sweep is accepted
    // and otherwise held, so the final value stays readable after done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + r_out_data;
        end
    end

    assign checksum = r_checksum;
`else
    // Without the checksum feature no accumulator is built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_dump.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_dump
//  Description : Self-checking bench for mem_dump. A word-list reference
//                model (expected address sequence + memory contents) is
//                compared against the streamed output under full, random and
//                stalling consumers, plus reset and ignored-start scenarios.
//                Honours MEM_DUMP_CHECKSUM_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump;

    localparam int INSTR_SIZE = 12;
    localparam int ADDR_SIZE  = 5;
    localparam int DEPTH      = 1 << ADDR_SIZE;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [ADDR_SIZE-1:0]  first_addr;
    logic [ADDR_SIZE-1:0]  last_addr;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_SIZE-1:0]  mem_rd_addr;
    logic [INSTR_SIZE-1:0] mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_SIZE-1:0]  out_addr;
    logic [INSTR_SIZE-1:0] out_data;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [INSTR_SIZE-1:0] checksum;
`endif

    logic [INSTR_SIZE-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    mem_dump #(
        .INSTR_SIZE (INSTR_SIZE),
        .ADDR_SIZE  (ADDR_SIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data)
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),        32'd0);
        chk({tag, "_done"},      32'(done),        32'd0);
        chk({tag, "_rd_en"},     32'(mem_rd_en),   32'd0);
        chk({tag, "_valid"},     32'(out_valid),   32'd0);
        chk({tag, "_rd_addr"},   32'(mem_rd_addr), 32'd0);
        chk({tag, "_out_addr"},  32'(out_addr),    32'd0);
        chk({tag, "_out_data"},  32'(out_data),    32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
        chk({tag, "_checksum"},  32'(checksum),    32'd0);
`endif
    endtask

    // One complete sweep. mode 0: consumer always ready (exact cycle timing
    // checked), mode 1: random readiness, mode 2: first word stalled 5 cycles.
    task automatic sweep(input logic [ADDR_SIZE-1:0] f, input logic [ADDR_SIZE-1:0] l,
                         input int mode, input bit inject_start);
        logic [ADDR_SIZE-1:0]  q[$];
        logic [ADDR_SIZE-1:0]  a;
        logic [ADDR_SIZE-1:0]  prev_addr;
        logic [INSTR_SIZE-1:0] prev_data;
        logic [INSTR_SIZE-1:0] exp_sum;
        bit                    prev_stall;
        bit                    finished;
        int                    n, idx, k, stall_cnt, budget;
        int                    done_cnt;

        // Reference: inclusive address list, wrapping modulo the depth.
        a = f;
        forever begin
            q.push_back(a);
            if (a == l) break;
            a = ADDR_SIZE'((int'(a) + 1) % DEPTH);
        end
        n          = q.size();
        idx        = 0;
        exp_sum    = '0;
        prev_stall = 1'b0;
        finished   = 1'b0;
        stall_cnt  = 0;
        done_cnt   = 0;
        prev_addr  = '0;
        prev_data  = '0;
        budget     = 60 * n + 10;

        @(negedge clk);
        start      = 1'b1;
        first_addr = f;
        last_addr  = l;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;

        while (!finished && k <= budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 99) < 50);
                default: begin
                    if (out_valid && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (inject_start && k == 4) begin
                start      = 1'b1;
                first_addr = ~f;
                last_addr  = ~l;
            end else begin
                start = 1'b0;
            end

            if (mode == 0) begin
                chk("t_valid", 32'(out_valid), 32'((k % 3 == 0) && (k <= 3 * n)));
                chk("t_rd_en", 32'(mem_rd_en), 32'((k % 3 == 1) && (k <= 3 * n)));
                chk("t_busy",  32'(busy),      32'(k <= 3 * n));
                chk("t_done",  32'(done),      32'(k == 3 * n + 1));
            end else if (!done) begin
                chk("busy_in_sweep", 32'(busy), 32'd1);
            end

            if (mem_rd_en && idx < n)
                chk("rd_addr", 32'(mem_rd_addr), 32'(q[idx]));

            if (out_valid) begin
                if (idx < n) begin
                    chk("out_addr", 32'(out_addr), 32'(q[idx]));
                    chk("out_data", 32'(out_data), 32'(mem[q[idx]]));
                end else begin
                    chk("extra_word", 32'(idx), 32'(n - 1));
                end
                if (prev_stall) begin
                    chk("stall_addr_hold", 32'(out_addr), 32'(prev_addr));
                    chk("stall_data_hold", 32'(out_data), 32'(prev_data));
                end
                if (!out_ready) chk("stall_no_rd", 32'(mem_rd_en), 32'd0);
                prev_addr = out_addr;
                prev_data = out_data;
                if (out_ready) begin
                    exp_sum = exp_sum + out_data;
                    idx++;
                end
            end
            prev_stall = out_valid && !out_ready;

            if (done) begin
                done_cnt++;
                chk("done_all_words", 32'(idx),  32'(n));
                chk("done_busy_low",  32'(busy), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
                chk("checksum_done", 32'(checksum), 32'(exp_sum));
`endif
                finished = 1'b1;
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            if (k == 1) chk("checksum_clear", 32'(checksum), 32'd0);
`endif
            @(negedge clk);
            k++;
        end
        start = 1'b0;

        if (!finished) chk("sweep_timeout", 32'd0, 32'd1);
        chk("done_once", 32'(done_cnt), 32'd1);
        // Cycle after done: back in IDLE, everything quiet.
        chk("post_done", 32'(done),      32'd0);
        chk("post_busy", 32'(busy),      32'd0);
        chk("post_valid", 32'(out_valid), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
        chk("checksum_hold", 32'(checksum), 32'(exp_sum));
`endif
    endtask

    initial begin
        int w;
        logic [ADDR_SIZE-1:0] rf;

        rst_n      = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_SIZE'($urandom);
        mem[0]  = 12'hA05;
        mem[1]  = 12'hC11;
        mem[16] = 12'h003;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed sweeps
        sweep(5'd0,  5'd1,  0, 1'b0);   // (0,A05),(1,C11); checksum 616
        sweep(5'd30, 5'd1,  0, 1'b0);   // wrap 30,31,0,1
        sweep(5'd16, 5'd16, 0, 1'b0);   // single word
        sweep(5'd5,  5'd7,  2, 1'b0);   // 5-cycle stall on first word
        sweep(5'd8,  5'd11, 0, 1'b1);   // start during sweep is ignored

        // Random sweeps with random consumer readiness
        for (int r = 0; r < 5; r++) begin
            rf = ADDR_SIZE'($urandom_range(0, DEPTH - 1));
            sweep(rf, ADDR_SIZE'((int'(rf) + int'($urandom_range(0, 5))) % DEPTH), 1, 1'b0);
        end

        // Reset while in SEND aborts the sweep
        @(negedge clk);
        start      = 1'b1;
        first_addr = 5'd0;
        last_addr  = 5'd3;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_reach_send", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        chk("midrst_idle",    32'(busy), 32'd0);
        sweep(5'd2, 5'd5, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
